// File: rtl/linked_stack_ctrl.sv
// Linked-list LIFO controller: entries are linked through link[] and come from an external allocator.
// Optional macro LINKED_STACK_ERR_EN adds a sticky err output for illegal requests.
module linked_stack_ctrl #(
  parameter int ADDR  = 4,
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop_valid,
  output logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_data_valid,
  input  logic             flush,
  output logic             empty,
  output logic             full,
  output logic [ADDR:0]    count,
  output logic             alloc,
  input  logic [ADDR-1:0]  alloc_addr,
  output logic             free,
  output logic [ADDR-1:0]  free_addr,
  output logic             move_vector,
  output logic [ADDR-1:0]  vector_start,
  output logic [ADDR-1:0]  vector_snd,
  output logic [ADDR-1:0]  vector_end,
  output logic             vector_size_is_one,
`ifdef LINKED_STACK_ERR_EN
  output logic             err,
`endif
  output logic [1:0]       fsm_state
);

  // Handshake: a push or pop is accepted in a cycle where its valid and ready are
  // both high; ready never depends on the same channel's valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POPRD = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] ONE_C   = (ADDR+1)'(1);

  state_t           state;
  logic [ADDR-1:0]  link_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR-1:0]  top;
  logic [ADDR-1:0]  bottom;
  logic [ADDR:0]    cnt;

  logic is_idle;
  logic flush_take;
  logic push_take;
  logic pop_take;
  logic swap;

  assign fsm_state = state;
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == DEPTH_C);

  // An accepted flush blocks push/pop in the same cycle; readies are held low in reset.
  assign is_idle    = (state == IDLE);
  assign flush_take = is_idle && flush && !empty;
  assign push_ready = rst_n && is_idle && !flush_take && (!full || pop_valid);
  assign pop_ready  = rst_n && is_idle && !flush_take && !empty;
  assign push_take  = push_valid && push_ready;
  assign pop_take   = pop_valid && pop_ready;
  assign swap       = push_take && pop_take;
  assign alloc      = push_take && !pop_take;
  assign free       = pop_take && !push_take;
  assign free_addr  = free ? top : '0;

  // Storage arrays carry no reset; they are only meaningful below count.
  always_ff @(posedge clk) begin
    if (alloc) begin
      data_mem[alloc_addr] <= push_data;
      link_mem[alloc_addr] <= top;
    end else if (swap) begin
      data_mem[top] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      top                <= '0;
      bottom             <= '0;
      pop_data           <= '0;
      pop_data_valid     <= 1'b0;
      move_vector        <= 1'b0;
      vector_start       <= '0;
      vector_snd         <= '0;
      vector_end         <= '0;
      vector_size_is_one <= 1'b0;
    end else begin
      pop_data_valid <= 1'b0;
      move_vector    <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_take) begin
            state              <= FLUSH;
            move_vector        <= 1'b1;
            vector_start       <= top;
            vector_snd         <= link_mem[top];
            vector_end         <= bottom;
            vector_size_is_one <= (cnt == ONE_C);
          end else if (swap) begin
            // Old top value is read here before the array write lands at this edge.
            pop_data       <= data_mem[top];
            pop_data_valid <= 1'b1;
            state          <= POPRD;
          end else if (alloc) begin
            top <= alloc_addr;
            cnt <= cnt + ONE_C;
            if (empty) bottom <= alloc_addr;
          end else if (free) begin
            top            <= link_mem[top];
            cnt            <= cnt - ONE_C;
            pop_data       <= data_mem[top];
            pop_data_valid <= 1'b1;
            state          <= POPRD;
          end
        end
        POPRD: state <= IDLE;
        FLUSH: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINKED_STACK_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (flush_take) begin
      err <= 1'b0;
    end else if (is_idle && ((push_valid && full && !pop_valid) || (pop_valid && empty))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_linked_stack_ctrl.sv
// Directed plus randomized bench for linked_stack_ctrl against a queue-based stack model
// with a bench-side free list acting as the allocator.
module tb_linked_stack_ctrl;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             push_valid = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             push_ready;
  logic             pop_valid = 1'b0;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;
  logic             pop_data_valid;
  logic             flush = 1'b0;
  logic             empty;
  logic             full;
  logic [ADDR:0]    count;
  logic             alloc;
  logic [ADDR-1:0]  alloc_addr = '0;
  logic             free;
  logic [ADDR-1:0]  free_addr;
  logic             move_vector;
  logic [ADDR-1:0]  vector_start;
  logic [ADDR-1:0]  vector_snd;
  logic [ADDR-1:0]  vector_end;
  logic             vector_size_is_one;
  logic [1:0]       fsm_state;

  linked_stack_ctrl #(.ADDR(ADDR), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .flush(flush), .empty(empty), .full(full), .count(count),
    .alloc(alloc), .alloc_addr(alloc_addr), .free(free), .free_addr(free_addr),
    .move_vector(move_vector), .vector_start(vector_start), .vector_snd(vector_snd),
    .vector_end(vector_end), .vector_size_is_one(vector_size_is_one),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // model: stack bottom at index 0; mode 0 = ready for requests, 1 = pop read-out, 2 = flush
  logic [ADDR-1:0]  stk_addr [$];
  logic [WIDTH-1:0] stk_data [$];
  logic [ADDR-1:0]  free_q   [$];
  int mode;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0;
    stk_addr.delete();
    stk_data.delete();
    free_q.delete();
    for (int i = 1; i < DEPTH; i++) free_q.push_back(ADDR'(i));
    free_q.push_back('0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_pop_data_valid"}, pop_data_valid, 0);
    check({tag, "_pop_data"}, pop_data, 0);
    check({tag, "_alloc"}, alloc, 0);
    check({tag, "_free"}, free, 0);
    check({tag, "_free_addr"}, free_addr, 0);
    check({tag, "_move_vector"}, move_vector, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push_valid = 1'b0; pop_valid = 1'b0; flush = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic pv, input logic [WIDTH-1:0] pd, input logic ppv, input logic fl);
    int size;
    logic idle, fl_acc, e_push_rdy, e_pop_rdy, p_acc, q_acc;
    logic [WIDTH-1:0] old_data;
    logic [ADDR-1:0] v_start, v_snd, v_end, a;
    logic v_one;
    old_data = '0; v_start = '0; v_snd = '0; v_end = '0; v_one = 1'b0;
    @(negedge clk);
    push_valid = pv; push_data = pd; pop_valid = ppv; flush = fl;
    alloc_addr = (free_q.size() > 0) ? free_q[0] : '0;
    #1;
    size       = stk_addr.size();
    idle       = (mode == 0);
    fl_acc     = idle && fl && (size > 0);
    e_push_rdy = idle && !fl_acc && ((size < DEPTH) || ppv);
    e_pop_rdy  = idle && !fl_acc && (size > 0);
    p_acc      = pv && e_push_rdy;
    q_acc      = ppv && e_pop_rdy;
    check("push_ready", push_ready, e_push_rdy);
    check("pop_ready", pop_ready, e_pop_rdy);
    check("alloc", alloc, p_acc && !q_acc);
    check("free", free, q_acc && !p_acc);
    check("free_addr", free_addr, (q_acc && !p_acc) ? stk_addr[size-1] : '0);

    if (mode == 2) begin
      while (stk_addr.size() > 0) free_q.push_back(stk_addr.pop_back());
      stk_data.delete();
    end
    if (fl_acc) begin
      v_start = stk_addr[size-1];
      v_end   = stk_addr[0];
      v_one   = (size == 1);
      if (size > 1) v_snd = stk_addr[size-2];
    end else if (p_acc && q_acc) begin
      old_data = stk_data[size-1];
      stk_data[size-1] = pd;
    end else if (p_acc) begin
      stk_addr.push_back(alloc_addr);
      stk_data.push_back(pd);
      void'(free_q.pop_front());
    end else if (q_acc) begin
      old_data = stk_data.pop_back();
      a = stk_addr.pop_back();
      free_q.push_back(a);
    end
    mode = fl_acc ? 2 : (q_acc ? 1 : 0);

    @(posedge clk);
    #1;
    check("pop_data_valid", pop_data_valid, q_acc);
    if (q_acc) check("pop_data", pop_data, old_data);
    check("move_vector", move_vector, fl_acc);
    if (fl_acc) begin
      check("vector_start", vector_start, v_start);
      check("vector_end", vector_end, v_end);
      check("vector_size_is_one", vector_size_is_one, v_one);
      if (!v_one) check("vector_snd", vector_snd, v_snd);
    end
    check("count", count, stk_addr.size());
    check("empty", empty, stk_addr.size() == 0);
    check("full", full, stk_addr.size() == DEPTH);
    check("fsm_state", fsm_state, mode);
  endtask

  initial begin
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // three pushes then three pops: LIFO order, one-cycle read-out, addresses released 3,2,1
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    step(1, 32'hC, 0, 0);
    check("three_push_count", count, 3);
    step(0, 0, 1, 0); check("pop1_data", pop_data, 32'hC); step(0, 0, 0, 0);
    step(0, 0, 1, 0); check("pop2_data", pop_data, 32'hB); step(0, 0, 0, 0);
    step(0, 0, 1, 0); check("pop3_data", pop_data, 32'hA); step(0, 0, 0, 0);

    // push+pop on empty acts as push; flush on empty is a no-op
    step(1, 32'h55, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // simultaneous push and pop on [A,B]
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    step(1, 32'hD, 1, 0); check("swap_data", pop_data, 32'hB);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0); check("after_swap_data", pop_data, 32'hD);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);

    // flush of three entries at addresses 1,2,3
    do_reset();
    step(1, 32'h1, 0, 0);
    step(1, 32'h2, 0, 0);
    step(1, 32'h3, 0, 0);
    step(1, 32'h4, 0, 1);
    check("flush_start", vector_start, 3);
    check("flush_snd", vector_snd, 2);
    check("flush_end", vector_end, 1);
    step(0, 0, 0, 0);
    check("flush_empty", empty, 1);

    // fill to full; a further push is dropped; push+pop at full replaces the top
    for (int i = 0; i < DEPTH; i++) step(1, WIDTH'($urandom), 0, 0);
    check("fill_full", full, 1);
    step(1, 32'hDEAD, 0, 0);
    check("overflow_count", count, DEPTH);
    step(1, 32'hBEEF, 1, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); check("full_top", pop_data, 32'hBEEF); step(0, 0, 0, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 0);

    // single-entry flush
    step(1, 32'h77, 0, 0);
    step(0, 0, 0, 1);
    check("single_flush_one", vector_size_is_one, 1);
    step(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 6), WIDTH'($urandom), $urandom_range(0, 1),
           ($urandom_range(0, 31) == 0));
    end

    // reset asserted during the read-out cycle of a pop
    while (stk_addr.size() < 2) step(1, WIDTH'($urandom), 0, 0);
    step(0, 0, 1, 0);
    rst_n = 1'b0;
    push_valid = 1'b1; pop_valid = 1'b1; flush = 1'b0;
    #1;
    check_reset_outputs("mid_pop_reset");
    @(negedge clk);
    push_valid = 1'b0; pop_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1, 32'h99, 0, 0);
    step(0, 0, 1, 0); check("post_reset_pop", pop_data, 32'h99);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
